// File: rtl/jogo_memoria_param.sv
// jogo_memoria_param: parametrised sequence-memory game core (FSM + datapath)
// Optional feature macro: JOGO_TIMEOUT_EN (per-play timeout counter and fim_timeout state)
// Ports:
//   clock, reset (async, active-low), iniciar (start a game from inicial or any fim state)
//   chaves[N_CHAVES]      player keys, one-hot is a valid play
//   acertou/errou/pronto  game result flags; timeout set only in fim_timeout
//   leds[N_CHAVES]        last registered play
//   db_estado[4], db_contagem[CW], db_esperado[N_CHAVES], db_tem_jogada  debug outputs
module jogo_memoria_param #(
   parameter int N_CHAVES = 4,
   parameter int N_JOGADAS = 16,
   parameter int TIMEOUT_CICLOS = 5000,
   localparam int CW = (N_JOGADAS > 1) ? $clog2(N_JOGADAS) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                iniciar,
   input  logic [N_CHAVES-1:0] chaves,
   output logic                acertou,
   output logic                errou,
   output logic                pronto,
   output logic                timeout,
   output logic [N_CHAVES-1:0] leds,
   output logic [3:0]          db_estado,
   output logic [CW-1:0]       db_contagem,
   output logic [N_CHAVES-1:0] db_esperado,
   output logic                db_tem_jogada
);
   typedef enum logic [3:0] {
      INICIAL     = 4'h0,
      PREPARACAO  = 4'h1,
      ESPERA      = 4'h2,
      REGISTRA    = 4'h3,
      COMPARA     = 4'h4,
      PROXIMA     = 4'h5,
      FIM_ACERTO  = 4'hA,
      FIM_ERRO    = 4'hE,
      FIM_TIMEOUT = 4'hF
   } estado_t;
   localparam logic [CW-1:0] ULTIMA = CW'(N_JOGADAS - 1);
   localparam logic [N_CHAVES-1:0] UM = N_CHAVES'(1);
   estado_t estado;
   logic [N_CHAVES-1:0] c_q, c_qq;
   assign db_estado     = estado;
   assign db_tem_jogada = (|c_q) && !(|c_qq);
   assign db_esperado   = UM << (db_contagem % N_CHAVES);
   // leds doubles as the play register, so compara checks what the player sees
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         c_q  <= '0;
         c_qq <= '0;
      end else begin
         c_q  <= chaves;
         c_qq <= c_q;
      end
`ifdef JOGO_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CICLOS);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CICLOS - 1);
   logic [TW-1:0] t_cnt;
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         estado      <= INICIAL;
         leds        <= '0;
         db_contagem <= '0;
         acertou     <= 1'b0;
         errou       <= 1'b0;
         pronto      <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
         timeout     <= 1'b0;
         t_cnt       <= '0;
`endif
      end else
         case (estado)
            INICIAL: if (iniciar) estado <= PREPARACAO;
            PREPARACAO: begin
               leds        <= '0;
               db_contagem <= '0;
               acertou     <= 1'b0;
               errou       <= 1'b0;
               pronto      <= 1'b0;
`ifdef JOGO_TIMEOUT_EN
               timeout     <= 1'b0;
               t_cnt       <= '0;
`endif
               estado      <= ESPERA;
            end
            ESPERA: begin
               // a play arriving on the expiry cycle takes priority over the timeout
               if (db_tem_jogada) estado <= REGISTRA;
`ifdef JOGO_TIMEOUT_EN
               else if (t_cnt == T_MAX) begin
                  errou   <= 1'b1;
                  pronto  <= 1'b1;
                  timeout <= 1'b1;
                  estado  <= FIM_TIMEOUT;
               end else t_cnt <= t_cnt + 1'b1;
`endif
            end
            REGISTRA: begin
               leds   <= c_q;
               estado <= COMPARA;
            end
            COMPARA:
               if (leds != db_esperado) begin
                  errou  <= 1'b1;
                  pronto <= 1'b1;
                  estado <= FIM_ERRO;
               end else if (db_contagem == ULTIMA) begin
                  acertou <= 1'b1;
                  pronto  <= 1'b1;
                  estado  <= FIM_ACERTO;
               end else estado <= PROXIMA;
            PROXIMA: begin
               if (db_contagem != ULTIMA) db_contagem <= db_contagem + 1'b1;
`ifdef JOGO_TIMEOUT_EN
               t_cnt <= '0;
`endif
               estado <= ESPERA;
            end
            FIM_ACERTO, FIM_ERRO, FIM_TIMEOUT: if (iniciar) estado <= PREPARACAO;
            default: estado <= INICIAL;
         endcase
endmodule

// File: tb/tb_jogo_memoria_param.sv
// tb_jogo_memoria_param: self-checking bench for jogo_memoria_param (N_CHAVES=4, N_JOGADAS=5)
`timescale 1ns/1ps
module tb_jogo_memoria_param;
   localparam int NC = 4;
   localparam int NJ = 5;
   localparam int TO = 20;
`ifdef JOGO_TIMEOUT_EN
   localparam int HOLD = 14;
   localparam int IDLE = 4;
`else
   localparam int HOLD = 30;
   localparam int IDLE = 10;
`endif
   logic clock = 1'b0, reset = 1'b0, iniciar = 1'b0;
   logic [NC-1:0] chaves = '0;
   logic acertou, errou, pronto, timeout, db_tem_jogada;
   logic [NC-1:0] leds, db_esperado;
   logic [3:0] db_estado;
   logic [2:0] db_contagem;
   typedef struct packed {
      logic       novo;
      logic [3:0] ch;
      logic [2:0] cnt;
      logic       ac;
      logic       er;
   } vec_t;
   vec_t exp_q[$];
   vec_t tab[11];
   int n_chk = 0, n_fail = 0;

   jogo_memoria_param #(.N_CHAVES(NC), .N_JOGADAS(NJ), .TIMEOUT_CICLOS(TO)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
      .acertou(acertou), .errou(errou), .pronto(pronto), .timeout(timeout),
      .leds(leds), .db_estado(db_estado), .db_contagem(db_contagem),
      .db_esperado(db_esperado), .db_tem_jogada(db_tem_jogada)
   );

   always #5 clock = ~clock;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nome, act, req);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_acertou"}, acertou, 0);
      chk({p, "_errou"}, errou, 0);
      chk({p, "_pronto"}, pronto, 0);
      chk({p, "_timeout"}, timeout, 0);
      chk({p, "_leds"}, leds, 0);
      chk({p, "_estado"}, db_estado, 0);
      chk({p, "_contagem"}, db_contagem, 0);
      chk({p, "_esperado"}, db_esperado, 1);
      chk({p, "_tem_jogada"}, db_tem_jogada, 0);
   endtask

   task automatic iniciar_jogo();
      @(negedge clock) iniciar = 1'b1;
      repeat (5) @(negedge clock);
      iniciar = 1'b0;
   endtask

   // drive one play; the result is checked four edges after the first sampling edge
   task automatic jogar(input vec_t v, input int hold, input int idle);
      vec_t e;
      int pulsos;
      pulsos = 0;
      exp_q.push_back(v);
      @(negedge clock) chaves = v.ch;
      for (int i = 1; i <= hold + idle; i++) begin
         @(negedge clock);
         pulsos += int'(db_tem_jogada);
         if (i == 5) begin
            e = exp_q.pop_front();
            chk("leds", leds, e.ch);
            chk("contagem", db_contagem, e.cnt);
            chk("acertou", acertou, e.ac);
            chk("errou", errou, e.er);
            chk("pronto", pronto, e.ac | e.er);
         end
         if (i == hold) chaves = '0;
      end
      chk("pulsos", pulsos, 1);
   endtask

   initial begin
      int n;
      tab = '{
         '{1'b1, 4'b0001, 3'd1, 1'b0, 1'b0},
         '{1'b0, 4'b0010, 3'd2, 1'b0, 1'b0},
         '{1'b0, 4'b0100, 3'd3, 1'b0, 1'b0},
         '{1'b0, 4'b1000, 3'd4, 1'b0, 1'b0},
         '{1'b0, 4'b0001, 3'd4, 1'b1, 1'b0},
         '{1'b1, 4'b0001, 3'd1, 1'b0, 1'b0},
         '{1'b0, 4'b0010, 3'd2, 1'b0, 1'b0},
         '{1'b0, 4'b0100, 3'd3, 1'b0, 1'b0},
         '{1'b0, 4'b1000, 3'd4, 1'b0, 1'b0},
         '{1'b0, 4'b0100, 3'd4, 1'b0, 1'b1},
         '{1'b1, 4'b0011, 3'd0, 1'b0, 1'b1}
      };
      repeat (3) @(negedge clock);
      chk_reset("rst0");
      reset = 1'b1;
      repeat (2) @(negedge clock);
      chk("idle_estado", db_estado, 0);
      for (int i = 0; i < 11; i++) begin
         if (tab[i].novo) iniciar_jogo();
         jogar(tab[i], 10, 10);
      end
      // asynchronous abort in the middle of a game
      iniciar_jogo();
      jogar('{1'b0, 4'b0001, 3'd1, 1'b0, 1'b0}, 10, 10);
      jogar('{1'b0, 4'b0010, 3'd2, 1'b0, 1'b0}, 10, 10);
      jogar('{1'b0, 4'b0100, 3'd3, 1'b0, 1'b0}, 10, IDLE);
      chk("pre_rst_contagem", db_contagem, 3);
      #2 reset = 1'b0;
      #1 chk_reset("rst1");
      @(negedge clock) reset = 1'b1;
      repeat (5) @(negedge clock);
      chk("post_rst_estado", db_estado, 0);
      // held key gives one pulse, then finish and restart
      iniciar_jogo();
      jogar('{1'b0, 4'b0001, 3'd1, 1'b0, 1'b0}, HOLD, IDLE);
      jogar('{1'b0, 4'b0010, 3'd2, 1'b0, 1'b0}, 10, IDLE);
      jogar('{1'b0, 4'b0100, 3'd3, 1'b0, 1'b0}, 10, IDLE);
      jogar('{1'b0, 4'b1000, 3'd4, 1'b0, 1'b0}, 10, IDLE);
      jogar('{1'b0, 4'b0001, 3'd4, 1'b1, 1'b0}, 10, IDLE);
      chk("fim_estado", db_estado, 4'hA);
      iniciar_jogo();
      chk("restart_contagem", db_contagem, 0);
      chk("restart_acertou", acertou, 0);
      chk("restart_errou", errou, 0);
      chk("restart_pronto", pronto, 0);
      chk("restart_estado", db_estado, 2);
      // idle player: timeout with the macro, endless wait without it
      reset = 1'b0;
      @(negedge clock) reset = 1'b1;
      @(negedge clock) iniciar = 1'b1;
      @(negedge clock) iniciar = 1'b0;
      n = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clock);
         if (db_estado == 4'h2) n++;
         else if (n > 0) break;
         if (n >= 1000) break;
      end
`ifdef JOGO_TIMEOUT_EN
      chk("espera_ciclos", n, TO);
      chk("to_estado", db_estado, 4'hF);
      chk("to_timeout", timeout, 1);
      chk("to_errou", errou, 1);
      chk("to_pronto", pronto, 1);
      chk("to_acertou", acertou, 0);
`else
      chk("espera_ciclos", n, 1000);
      chk("to_estado", db_estado, 4'h2);
      chk("to_timeout", timeout, 0);
      chk("to_pronto", pronto, 0);
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
